round_robin_arbiter_n: RTL and testbench

ROUND_ROBIN_ARBITER_N -- requirements
Module: round_robin_arbiter_n

---
 rtl/round_robin_arbiter_n_pkg.sv | 12 +
 rtl/round_robin_arbiter_n_pick.sv | 35 +++
 rtl/round_robin_arbiter_n.sv | 96 +++++++++
 tb/tb_round_robin_arbiter_n.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter_n_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
package rr_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int RR_DEFAULT_N       = 4;
  localparam int RR_DEFAULT_HOLD_EN = 1;

endpackage

// File: rtl/round_robin_arbiter_n_pick.sv
// Combinational cyclic priority pick: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW:0]   sum;
  logic [IW-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k stays below 2N, so one conditional subtract is a full modulo
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      j = sum[IW-1:0];
      if (!valid && req[j]) begin
        valid  = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter_n.sv
// N-way round-robin arbiter with optional burst lock held until the owner flags last.
module round_robin_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int N       = RR_DEFAULT_N,
  parameter int HOLD_EN = RR_DEFAULT_HOLD_EN,
  localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  requests,
  input  logic [N-1:0]  last,
  output logic [N-1:0]  grants,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] lk_idx_q, lk_idx_d;

  logic [IW-1:0] pick_ptr;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;

  logic          hold;
  logic          win_valid;
  logic [IW-1:0] win_idx;
  logic [N-1:0]  win_gnt;
  logic          release_ok;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(N-1)) ? '0 : i + 1'b1;
  endfunction

  // A lock whose owner dropped its request releases this cycle, scanning from just past the owner
  always_comb begin
    hold     = (state_q == LOCKED) && requests[lk_idx_q];
    pick_ptr = (state_q == LOCKED) ? next_idx(lk_idx_q) : ptr_q;
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (requests),
    .ptr   (pick_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    win_valid  = hold || pick_valid;
    win_idx    = hold ? lk_idx_q : pick_idx;
    win_gnt    = hold ? (N'(1) << lk_idx_q) : pick_gnt;
    release_ok = (HOLD_EN == 0) || last[win_idx];

    state_d  = state_q;
    ptr_d    = ptr_q;
    lk_idx_d = lk_idx_q;
    if (win_valid) begin
      if (release_ok) begin
        ptr_d   = next_idx(win_idx);
        state_d = ARB;
      end else begin
        state_d  = LOCKED;
        lk_idx_d = win_idx;
      end
    end else if (state_q == LOCKED) begin
      ptr_d   = next_idx(lk_idx_q);
      state_d = ARB;
    end
  end

  // Outputs are forced quiet for the whole time reset is held
  always_comb begin
    grants      = (win_valid && !rst) ? win_gnt : '0;
    grant_idx   = (win_valid && !rst) ? win_idx : '0;
    grant_valid = win_valid && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      lk_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      lk_idx_q <= lk_idx_d;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter_n.sv
// Bench for round_robin_arbiter_n: three configurations against a cyclic-scan reference model.
module tb_round_robin_arbiter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] reqA, lastA, gntA;
  logic       idxA, vldA;
  logic [3:0] reqB, lastB, gntB;
  logic [1:0] idxB;
  logic       vldB;
  logic [3:0] reqC, lastC, gntC;
  logic [1:0] idxC;
  logic       vldC;

  round_robin_arbiter_n #(.N(2), .HOLD_EN(0)) dut_a (
    .clk(clk), .rst(rst), .requests(reqA), .last(lastA),
    .grants(gntA), .grant_idx(idxA), .grant_valid(vldA));
  round_robin_arbiter_n #(.N(4), .HOLD_EN(0)) dut_b (
    .clk(clk), .rst(rst), .requests(reqB), .last(lastB),
    .grants(gntB), .grant_idx(idxB), .grant_valid(vldB));
  round_robin_arbiter_n #(.N(4), .HOLD_EN(1)) dut_c (
    .clk(clk), .rst(rst), .requests(reqC), .last(lastC),
    .grants(gntC), .grant_idx(idxC), .grant_valid(vldC));

  int n_checks = 0;
  int n_fail   = 0;

  int NN [3] = '{2, 4, 4};
  int HH [3] = '{0, 0, 1};
  int m_ptr [3];
  int m_lk  [3];
  bit m_locked [3];

  function automatic logic bit_of(logic [3:0] v, int i);
    return v[i[1:0]];
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_ptr[d] = 0; m_lk[d] = 0; m_locked[d] = 1'b0;
    end
  endfunction

  // Winner index per the arbitration rules, -1 when nobody is granted
  function automatic int ref_pick(int d, logic [3:0] req);
    int start;
    if (m_locked[d] && bit_of(req, m_lk[d])) return m_lk[d];
    start = m_locked[d] ? (m_lk[d] + 1) % NN[d] : m_ptr[d];
    for (int k = 0; k < NN[d]; k++)
      if (bit_of(req, (start + k) % NN[d])) return (start + k) % NN[d];
    return -1;
  endfunction

  function automatic void ref_advance(int d, logic [3:0] req, logic [3:0] lst);
    int w;
    w = ref_pick(d, req);
    if (w < 0) begin
      if (m_locked[d]) begin
        m_ptr[d] = (m_lk[d] + 1) % NN[d];
        m_locked[d] = 1'b0;
      end
    end else if (HH[d] == 0 || bit_of(lst, w)) begin
      m_ptr[d] = (w + 1) % NN[d];
      m_locked[d] = 1'b0;
    end else begin
      m_locked[d] = 1'b1;
      m_lk[d] = w;
    end
  endfunction

  task automatic set_in(int d, logic [3:0] r, logic [3:0] l);
    case (d)
      0: begin reqA = r[1:0]; lastA = l[1:0]; end
      1: begin reqB = r; lastB = l; end
      default: begin reqC = r; lastC = l; end
    endcase
  endtask

  function automatic void get_in(int d, output logic [3:0] r, output logic [3:0] l);
    case (d)
      0: begin r = {2'b00, reqA}; l = {2'b00, lastA}; end
      1: begin r = reqB; l = lastB; end
      default: begin r = reqC; l = lastC; end
    endcase
  endfunction

  function automatic void get_obs(int d, output logic [3:0] g, output int i, output logic v);
    case (d)
      0: begin g = {2'b00, gntA}; i = int'(idxA); v = vldA; end
      1: begin g = gntB; i = int'(idxB); v = vldB; end
      default: begin g = gntC; i = int'(idxC); v = vldC; end
    endcase
  endfunction

  // Called at a negedge: advance the models, cross a rising edge, return at the next negedge
  task automatic next_cycle();
    logic [3:0] r, l;
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        get_in(d, r, l);
        ref_advance(d, r, l);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] g; int i; logic v;
    rst = 1'b1;
    model_reset();
    for (int d = 0; d < 3; d++) set_in(d, 4'hF, 4'h0);
    #1;
    for (int d = 0; d < 3; d++) begin
      get_obs(d, g, i, v);
      n_checks++;
      if (g !== 4'h0 || v !== 1'b0 || i != 0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: grants=%b idx=%0d valid=%b, required 0000/0/0", d, g, i, v);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 3; d++) set_in(d, 4'h0, 4'h0);
    #1;
    for (int d = 0; d < 3; d++) begin
      get_obs(d, g, i, v);
      n_checks++;
      if (g !== 4'h0 || v !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset dut%0d: grants=%b valid=%b, required 0000/0", d, g, v);
      end
    end
  endtask

  task automatic test_n2_sequence();
    logic [1:0] rq [10] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
    logic [1:0] ex [10] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b01};
    logic [3:0] g; int i; logic v;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      set_in(0, {2'b00, rq[k]}, 4'h0);
      #1;
      get_obs(0, g, i, v);
      n_checks++;
      if (g[1:0] !== ex[k] || v !== (ex[k] != 2'b00)) begin
        n_fail++;
        $display("FAIL n2_seq[%0d]: grants=%b valid=%b, required %b", k, g[1:0], v, ex[k]);
      end
      next_cycle();
    end
    set_in(0, 4'h0, 4'h0);
  endtask

  task automatic test_fairness();
    logic [3:0] g; int i; logic v;
    int seen [4] = '{0, 0, 0, 0};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_in(1, 4'hF, 4'h0);
      #1;
      get_obs(1, g, i, v);
      n_checks++;
      if (i != k % 4 || v !== 1'b1 || g !== (4'b0001 << (k % 4))) begin
        n_fail++;
        $display("FAIL fair[%0d]: idx=%0d grants=%b valid=%b, required idx %0d", k, i, g, v, k % 4);
      end
      if (k < 4) seen[i[1:0]]++;
      next_cycle();
    end
    n_checks++;
    if (seen[0] != 1 || seen[1] != 1 || seen[2] != 1 || seen[3] != 1) begin
      n_fail++;
      $display("FAIL fair_window: counts %0d %0d %0d %0d, required 1 each", seen[0], seen[1], seen[2], seen[3]);
    end
    set_in(1, 4'h0, 4'h0);
  endtask

  task automatic test_burst_hold();
    logic [3:0] g; int i; logic v;
    int ex [5] = '{0, 0, 0, 0, 2};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(2, 4'b0101, (k == 3) ? 4'b0001 : 4'b0000);
      #1;
      get_obs(2, g, i, v);
      n_checks++;
      if (i != ex[k] || v !== 1'b1) begin
        n_fail++;
        $display("FAIL burst[%0d]: idx=%0d valid=%b, required idx %0d", k, i, v, ex[k]);
      end
      next_cycle();
    end
    set_in(2, 4'h0, 4'h0);
    next_cycle();
  endtask

  task automatic test_lock_release();
    logic [3:0] g; int i; logic v;
    do_reset();
    set_in(2, 4'b0010, 4'b0000);
    #1;
    get_obs(2, g, i, v);
    n_checks++;
    if (i != 1 || v !== 1'b1) begin
      n_fail++;
      $display("FAIL lock_on_1: idx=%0d valid=%b, required 1/1", i, v);
    end
    next_cycle();
    set_in(2, 4'b1001, 4'b0000);
    #1;
    get_obs(2, g, i, v);
    n_checks++;
    if (i != 3 || v !== 1'b1 || g !== 4'b1000) begin
      n_fail++;
      $display("FAIL release_same_cycle: idx=%0d grants=%b valid=%b, required 3/1000/1", i, g, v);
    end
    next_cycle();
    set_in(2, 4'h0, 4'h0);
    next_cycle();
  endtask

  task automatic test_wrap();
    logic [3:0] g; int i; logic v;
    logic [3:0] rq [3] = '{4'b0100, 4'b1000, 4'b1111};
    logic [3:0] ls [3] = '{4'b0100, 4'b1000, 4'b0000};
    int ex [3] = '{2, 3, 0};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(2, rq[k], ls[k]);
      #1;
      get_obs(2, g, i, v);
      n_checks++;
      if (i != ex[k] || v !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap[%0d]: idx=%0d valid=%b, required idx %0d", k, i, v, ex[k]);
      end
      next_cycle();
    end
    set_in(2, 4'h0, 4'h0);
    next_cycle();
  endtask

  task automatic test_reset_mid_lock();
    logic [3:0] g; int i; logic v;
    do_reset();
    set_in(2, 4'b0100, 4'b0000);
    next_cycle();
    set_in(2, 4'b1111, 4'b0000);
    #1;
    get_obs(2, g, i, v);
    n_checks++;
    if (i != 2 || g !== 4'b0100) begin
      n_fail++;
      $display("FAIL held_lock_2: idx=%0d grants=%b, required 2/0100", i, g);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    get_obs(2, g, i, v);
    n_checks++;
    if (g !== 4'h0 || v !== 1'b0 || i != 0) begin
      n_fail++;
      $display("FAIL async_reset_grants: grants=%b idx=%0d valid=%b, required 0000/0/0", g, i, v);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    get_obs(2, g, i, v);
    n_checks++;
    if (i != 0 || v !== 1'b1 || g !== 4'b0001) begin
      n_fail++;
      $display("FAIL after_reset_from_0: idx=%0d grants=%b valid=%b, required 0/0001/1", i, g, v);
    end
    next_cycle();
    set_in(2, 4'h0, 4'h0);
    next_cycle();
  endtask

  task automatic test_random();
    logic [3:0] g, eg; int i, w; logic v;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      for (int d = 0; d < 3; d++)
        set_in(d, 4'($urandom_range(0, 15)), 4'($urandom & $urandom));
      #1;
      for (int d = 0; d < 3; d++) begin
        logic [3:0] r, l;
        get_in(d, r, l);
        w  = ref_pick(d, r);
        eg = (w < 0) ? 4'h0 : (4'b0001 << w);
        get_obs(d, g, i, v);
        n_checks++;
        if (g !== eg || i != ((w < 0) ? 0 : w) || v !== (w >= 0)) begin
          n_fail++;
          $display("FAIL random[%0d] dut%0d req=%b: grants=%b idx=%0d valid=%b, required %b/%0d/%b",
                   k, d, r, g, i, v, eg, (w < 0) ? 0 : w, (w >= 0));
        end
      end
      next_cycle();
    end
    for (int d = 0; d < 3; d++) set_in(d, 4'h0, 4'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_n2_sequence();
    test_fairness();
    test_burst_hold();
    test_lock_release();
    test_wrap();
    test_reset_mid_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
